// File: rtl/axi_pkg.sv
// Shared AXI slave definitions: FSM states, burst types and response codes.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  // Polarity matches the master's completion check on BRESP.
  localparam logic RESP_OKAY = 1'b1;
  localparam logic RESP_ERR  = 1'b0;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address tracker: holds the current byte address, steps it per beat
// (INCR) or holds it (FIXED), and flags addresses beyond the memory window.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ADDR_WIDTH-1:0]     load_addr,
  input  logic [2:0]                load_size,
  input  logic [1:0]                load_burst,
  input  logic                      step,
  output logic [MEM_ADDR_WIDTH-1:0] word_idx,
  output logic                      out_of_range
);

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]            size;
  logic [1:0]            burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      size     <= '0;
      burst    <= '0;
    end else if (load) begin
      cur_addr <= load_addr;
      size     <= load_size;
      burst    <= load_burst;
    end else if (step && burst != BURST_FIXED) begin
      // Any non-FIXED encoding behaves as INCR; the sum wraps naturally.
      cur_addr <= cur_addr + (ADDR_WIDTH'(1) << size);
    end
  end

  assign word_idx     = cur_addr[MEM_ADDR_WIDTH+1:2];
  assign out_of_range = (cur_addr >> (MEM_ADDR_WIDTH + 2)) != '0;

endmodule

// File: rtl/axi_slave_write_channel.sv
// AXI-style write slave: takes one AW burst, writes each W beat straight to a
// word-addressed memory port, then returns a single B response.
module axi_slave_write_channel
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8,
  parameter int MEM_ADDR_WIDTH      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [WRITE_BURST_LEN-1:0]     AWLEN,
  input  logic [2:0]                     AWSIZE,
  input  logic [1:0]                     AWBURST,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
  input  logic                           WLAST,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic                           BRESP,
  output logic                           mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_waddr,
  output logic [WRITE_CHANNEL_WIDTH-1:0] mem_wdata,
  output logic                           busy
);

  state_t                     state, state_nxt;
  logic [WRITE_BURST_LEN-1:0] len, beat_cnt;
  logic                       err;
  logic                       aw_hs, w_hs, b_hs, last_beat;
  logic [MEM_ADDR_WIDTH-1:0]  word_idx;
  logic                       oor;

  // Ready/valid are pure state decodes, forced low while reset is applied.
  assign AWREADY   = !rst && state == ST_IDLE;
  assign WREADY    = !rst && state == ST_DATA;
  assign BVALID    = !rst && state == ST_RESP;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = beat_cnt == len;

  axi_burst_addr_gen #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (aw_hs),
    .load_addr   (AWADDR),
    .load_size   (AWSIZE),
    .load_burst  (AWBURST),
    .step        (w_hs),
    .word_idx    (word_idx),
    .out_of_range(oor)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (aw_hs) state_nxt = ST_DATA;
      // Burst ends on the counted last beat or an early WLAST, whichever first.
      ST_DATA: if (w_hs && (last_beat || WLAST)) state_nxt = ST_RESP;
      ST_RESP: if (b_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (aw_hs) begin
      len      <= AWLEN;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      if ((WLAST != last_beat) || oor) err <= 1'b1;
    end
  end

  assign mem_we    = w_hs && !oor;
  assign mem_waddr = w_hs ? word_idx : '0;
  assign mem_wdata = w_hs ? WDATA : '0;
  assign BRESP     = BVALID ? (err ? RESP_ERR : RESP_OKAY) : RESP_ERR;
  assign busy      = state != ST_IDLE;

endmodule

// File: tb/tb_axi_slave_write_channel.sv
// Directed bench for axi_slave_write_channel: a burst-level model predicts the
// memory writes and responses; a per-cycle monitor checks the DUT against it.
module tb_axi_slave_write_channel;

  localparam int AW = 32, DW = 32, LW = 8, MW = 10;

  logic          clk = 1'b0, rst = 1'b1;
  logic          AWVALID = 0, AWREADY;
  logic [AW-1:0] AWADDR = '0;
  logic [LW-1:0] AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic [1:0]    AWBURST = '0;
  logic          WVALID = 0, WREADY, WLAST = 0;
  logic [DW-1:0] WDATA = '0;
  logic          BVALID, BREADY = 0, BRESP;
  logic          mem_we, busy;
  logic [MW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  axi_slave_write_channel #(
    .ADDR_WIDTH(AW), .WRITE_CHANNEL_WIDTH(DW),
    .WRITE_BURST_LEN(LW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0, n_fail = 0, we_cnt = 0;
  logic [DW-1:0] obs_mem [0:(1<<MW)-1];
  logic          obs_bresp = 1'bx;
  logic [MW-1:0] exp_waddr [$];
  logic [DW-1:0] exp_wdata [$];
  logic          exp_resp  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++; n_fail++;
    $display("FAIL %s: got event want none @%0t", name, $time);
  endtask

  // Burst-level model: which beats get sent, where they land, and the response.
  task automatic model(input logic [31:0] addr, input int len, input logic [2:0] size,
                       input logic [1:0] bt, input int last_at, input logic [31:0] dbase,
                       output int nbeats);
    bit          err = 0;
    logic [31:0] a;
    nbeats = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
    for (int i = 0; i < nbeats; i++) begin
      a = (bt == 2'd0) ? addr : addr + (32'(i) << size);
      if ((i == last_at) != (i == len)) err = 1;
      if ((a >> (MW + 2)) != 0) err = 1;
      else begin
        exp_waddr.push_back(a[MW+1:2]);
        exp_wdata.push_back(dbase + 32'(i));
      end
    end
    exp_resp.push_back(!err);
  endtask

  // Monitor: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_excl", {31'b0, (AWREADY & WREADY) | (AWREADY & BVALID) | (WREADY & BVALID)}, 0);
      if (mem_we) begin
        check("we_on_beat", {31'b0, WVALID & WREADY}, 1);
        we_cnt++;
        obs_mem[mem_waddr] = mem_wdata;
        if (exp_waddr.size() == 0) flag("extra_mem_we");
        else begin
          check("mem_waddr", 32'(mem_waddr), 32'(exp_waddr.pop_front()));
          check("mem_wdata", mem_wdata, exp_wdata.pop_front());
        end
      end
      if (BVALID) begin
        if (exp_resp.size() == 0) flag("extra_bvalid");
        else begin
          check("bresp", {31'b0, BRESP}, {31'b0, exp_resp[0]});
          if (BREADY) begin
            obs_bresp = BRESP;
            void'(exp_resp.pop_front());
          end
        end
      end
    end
  end

  task automatic aw_phase(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] bt);
    bit hs = 0;
    AWVALID = 1; AWADDR = addr; AWLEN = LW'(len); AWSIZE = size; AWBURST = bt;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge clk); hs = AWREADY;
      @(posedge clk); #1;
    end
    if (!hs) flag("aw_timeout");
    AWVALID = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    WVALID = 1; WDATA = d; WLAST = last;
    @(negedge clk); check("wready", {31'b0, WREADY}, 1);
    @(posedge clk); #1;
    WVALID = 0; WLAST = 0;
  endtask

  task automatic burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                       input logic [1:0] bt, input int last_at, input int gap,
                       input int bdelay, input logic [31:0] dbase);
    int nb;
    model(addr, len, size, bt, last_at, dbase, nb);
    aw_phase(addr, len, size, bt);
    for (int i = 0; i < nb; i++) begin
      if (gap > 0 && i > 0) repeat (gap) begin @(posedge clk); #1; end
      send_beat(dbase + 32'(i), i == last_at);
    end
    BREADY = 0;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk); check("bvalid_hold", {31'b0, BVALID}, 1);
      @(posedge clk); #1;
    end
    BREADY = 1;
    @(negedge clk); check("bvalid", {31'b0, BVALID}, 1);
    @(posedge clk); #1; BREADY = 0;
    @(negedge clk);
    check("awready_after_b", {31'b0, AWREADY}, 1);
    check("bvalid_clear", {31'b0, BVALID}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    @(posedge clk); #1;
    @(negedge clk); check("rst_awready_low", {31'b0, AWREADY}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("rst_awready", {31'b0, AWREADY}, 1);
    check("rst_wready",  {31'b0, WREADY}, 0);
    check("rst_bvalid",  {31'b0, BVALID}, 0);
    check("rst_bresp",   {31'b0, BRESP}, 0);
    check("rst_mem_we",  {31'b0, mem_we}, 0);
    check("rst_waddr",   32'(mem_waddr), 0);
    check("rst_wdata",   mem_wdata, 0);
    check("rst_busy",    {31'b0, busy}, 0);
    @(posedge clk); #1;

    w0 = we_cnt; burst(32'h100, 3, 3'd2, 2'd1, 3, 0, 0, 32'hA0);
    check("t1_writes", 32'(we_cnt - w0), 4);
    check("t1_w40", obs_mem[10'h40], 32'hA0);
    check("t1_w43", obs_mem[10'h43], 32'hA3);
    check("t1_bresp", {31'b0, obs_bresp}, 1);

    w0 = we_cnt; burst(32'h20, 2, 3'd2, 2'd0, 2, 0, 0, 32'hB0);
    check("fixed_writes", 32'(we_cnt - w0), 3);
    check("fixed_w08", obs_mem[10'h08], 32'hB2);
    check("fixed_bresp", {31'b0, obs_bresp}, 1);

    w0 = we_cnt; burst(32'h300, 3, 3'd2, 2'd1, 3, 1, 5, 32'hC0);
    check("bp_writes", 32'(we_cnt - w0), 4);
    check("bp_bresp", {31'b0, obs_bresp}, 1);

    w0 = we_cnt; burst(32'h40, 3, 3'd2, 2'd1, 1, 0, 0, 32'hD0);
    check("early_writes", 32'(we_cnt - w0), 2);
    check("early_bresp", {31'b0, obs_bresp}, 0);
    burst(32'h80, 1, 3'd2, 2'd1, 1, 0, 0, 32'hE0);
    check("after_err_bresp", {31'b0, obs_bresp}, 1);

    w0 = we_cnt; burst(32'h1000, 0, 3'd2, 2'd1, 0, 0, 0, 32'hF0);
    check("oor_writes", 32'(we_cnt - w0), 0);
    check("oor_bresp", {31'b0, obs_bresp}, 0);

    w0 = we_cnt; burst(32'h180, 1, 3'd2, 2'd1, -1, 0, 0, 32'h90);
    check("nolast_writes", 32'(we_cnt - w0), 2);
    check("nolast_bresp", {31'b0, obs_bresp}, 0);

    burst(32'h3FF, 2, 3'd0, 2'd3, 2, 0, 0, 32'h70);
    check("byte_w100", obs_mem[10'h100], 32'h72);
    check("byte_bresp", {31'b0, obs_bresp}, 1);

    w0 = we_cnt; burst(32'hFFC, 1, 3'd2, 2'd1, 1, 0, 0, 32'h60);
    check("edge_writes", 32'(we_cnt - w0), 1);
    check("edge_bresp", {31'b0, obs_bresp}, 0);

    w0 = we_cnt; burst(32'h0, 255, 3'd2, 2'd1, 255, 0, 0, 32'h1000);
    check("max_writes", 32'(we_cnt - w0), 256);
    check("max_wff", obs_mem[10'hFF], 32'h10FF);
    check("max_bresp", {31'b0, obs_bresp}, 1);

    // Reset after two beats of an 8-beat burst.
    w0 = we_cnt;
    exp_waddr.push_back(10'h80); exp_wdata.push_back(32'h50);
    exp_waddr.push_back(10'h81); exp_wdata.push_back(32'h51);
    aw_phase(32'h200, 7, 3'd2, 2'd1);
    send_beat(32'h50, 0);
    send_beat(32'h51, 0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("mid_rst_awready", {31'b0, AWREADY}, 1);
    check("mid_rst_bvalid",  {31'b0, BVALID}, 0);
    check("mid_rst_wready",  {31'b0, WREADY}, 0);
    check("mid_rst_busy",    {31'b0, busy}, 0);
    check("mid_rst_writes",  32'(we_cnt - w0), 2);
    check("mid_rst_w81",     obs_mem[10'h81], 32'h51);
    @(posedge clk); #1;
    burst(32'h200, 1, 3'd2, 2'd1, 1, 0, 0, 32'h30);
    check("post_rst_bresp", {31'b0, obs_bresp}, 1);
    check("post_rst_w81", obs_mem[10'h81], 32'h31);

    repeat (3) @(posedge clk);
    check("writes_drained", 32'(exp_waddr.size()), 0);
    check("resps_drained", 32'(exp_resp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_slave_write_channel.md
# axi_slave_write_channel

AXI-style write-side slave that terminates the AW, W and B channels driven by the DMA-side write master. Per burst it:
- latches one address/length,
- accepts the data beats,
- writes each beat into a word-addressed memory port,
- returns a single write response.

It sits directly downstream of the master write channel, in front of the data RAM.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on AWADDR
- WRITE_CHANNEL_WIDTH, 32, WDATA and memory word width
- WRITE_BURST_LEN, 8, AWLEN width; a burst is AWLEN+1 beats
- MEM_ADDR_WIDTH, 10, memory word-index width (depth 2^MEM_ADDR_WIDTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- AWADDR  in  ADDR_WIDTH  burst start byte address
- AWLEN  in  WRITE_BURST_LEN  beats minus one
- AWSIZE  in  3  bytes per beat = 1<<AWSIZE
- AWBURST  in  2  0 = FIXED, 1 = INCR, others treated as INCR
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- WDATA  in  WRITE_CHANNEL_WIDTH  beat data
- WLAST  in  1  final beat marker
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BRESP  out  1  1 = OKAY, 0 = error
- mem_we  out  1  memory write strobe
- mem_waddr  out  MEM_ADDR_WIDTH  memory word index
- mem_wdata  out  WRITE_CHANNEL_WIDTH  memory write data
- busy  out  1  high in any state other than IDLE

## Operation
States: IDLE, DATA, RESP.

IDLE
- AWREADY=1.
- On AWVALID&&AWREADY:
  - latch AWADDR into cur_addr, AWLEN into len, AWSIZE, AWBURST;
  - clear beat_cnt and err;
  - go to DATA.

DATA
- WREADY=1.
- Each W handshake:
  - mem_we=1, mem_wdata=WDATA, mem_waddr=cur_addr[MEM_ADDR_WIDTH+1:2] (combinational, same cycle);
  - beat_cnt+1;
  - if INCR, cur_addr += 1<<size (wraps modulo 2^ADDR_WIDTH); FIXED holds cur_addr.
- err is set if any of these occur:
  - WLAST high while beat_cnt<len (early last);
  - WLAST low while beat_cnt==len;
  - cur_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] nonzero (out of range).
- Out-of-range beats are still accepted but mem_we=0.
- Leave DATA on the handshake where beat_cnt==len, or on an early WLAST, whichever comes first; go to RESP.
- A missing WLAST does not extend the burst.

RESP
- BVALID=1, BRESP=!err.
- On BVALID&&BREADY go to IDLE.

Other rules:
- mem_we is only ever high on an accepted W beat.
- AWREADY, WREADY and BVALID are never asserted together.
- The AW/W signals of the next burst are ignored until IDLE.

## Timing
- Reset values: state=IDLE, AWREADY=1 (IDLE decode; low during the reset cycle itself), WREADY=0, BVALID=0, BRESP=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, and all latched registers 0.
- AW handshake at cycle t: WREADY high from t+1.
- Beat n write occurs in its handshake cycle (zero-latency memory strobe).
- Last W handshake at cycle t: BVALID high from t+1 and held until BREADY; BRESP is stable while BVALID is high.
- B handshake at t: AWREADY high at t+1. Minimum burst turnaround is len+3 cycles.
- WVALID low stalls DATA indefinitely with no state change.
- Reset mid-burst: return to IDLE next edge; no partial response is issued; the memory keeps the beats already written.
- beat_cnt is WRITE_BURST_LEN bits wide; AWLEN=2^WRITE_BURST_LEN-1 completes without overflow because comparison precedes the increment.

## Structure
- Shared package (axi_pkg) holds:
  - state encodings (IDLE/DATA/RESP);
  - burst-type constants BURST_FIXED=0 and BURST_INCR=1;
  - RESP_OKAY=1 and RESP_ERR=0, matching the master's completion check on BRESP.
- One natural sub-module: axi_burst_addr_gen, holding cur_addr, the INCR/FIXED step and the range check. It is reusable by the future read-slave channel.

## Test plan
- Single INCR burst: AWADDR=0x100, AWLEN=3, AWSIZE=2, data A0..A3 with WLAST on beat 3 -> mem_waddr 0x40..0x43 receive A0..A3, one BVALID with BRESP=1, AWREADY high the cycle after the B handshake.
- FIXED burst: AWADDR=0x20, AWLEN=2, AWBURST=0 -> three writes all at word 0x08, final value is the last beat, BRESP=1.
- Backpressure: WVALID toggled every other cycle and BREADY held low 5 cycles -> no extra mem_we, BVALID and BRESP held stable until BREADY.
- Protocol error: AWLEN=3 with WLAST on beat 1 -> 2 writes, then RESP with BRESP=0; next burst completes with BRESP=1.
- Out of range: AWADDR=0x1000 (MEM_ADDR_WIDTH=10), AWLEN=0 -> beat accepted, mem_we stays 0, BRESP=0.
- Reset mid-burst: rst asserted after beat 1 of AWLEN=7 -> next cycle IDLE, BVALID=0, AWREADY=1, and a fresh burst completes normally.
